// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable data width, optional parity, 1 or 2 stop bits,
// zero-gap back-to-back frames on a valid/ready producer interface.
module uart_tx_frame #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] READY_TICK = TW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_param_check
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_next;
    logic [TW-1:0]        timer, timer_next;
    logic [3:0]           bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_next;
    logic                 txd_next, ready_next, busy_next, done_next;
    logic                 bit_end, accept, start_frame, last_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            shreg    <= shreg_next;
            par_bit  <= par_next;
            txd      <= txd_next;
            tx_ready <= ready_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next    = state;
        timer_next    = timer + TW'(1);
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        shreg_next    = shreg;
        par_next      = par_bit;
        txd_next      = txd;
        ready_next    = 1'b0;
        busy_next     = tx_busy;
        done_next     = 1'b0;
        start_frame   = 1'b0;
        bit_end       = (timer == LAST_TICK);
        accept        = tx_valid && tx_ready;
        last_stop     = (stop_cnt == LAST_STOP);

        case (state)
            IDLE: begin
                timer_next = '0;
                ready_next = 1'b1;
                if (accept) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    timer_next   = '0;
                    bit_cnt_next = '0;
                    txd_next     = shreg[0];
                    shreg_next   = shreg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_next = '0;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_MODE != 0) begin
                            state_next = PARITY;
                            txd_next   = par_bit;
                        end else begin
                            state_next    = STOP;
                            stop_cnt_next = 1'b0;
                            txd_next      = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                        txd_next     = shreg[0];
                        shreg_next   = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    timer_next    = '0;
                    stop_cnt_next = 1'b0;
                    txd_next      = 1'b1;
                end
            end
            STOP: begin
                if (last_stop && timer == READY_TICK) begin
                    ready_next = 1'b1;
                end
                if (bit_end) begin
                    timer_next = '0;
                    if (!last_stop) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        // The final stop cycle doubles as an accept slot so frames can abut.
                        done_next = 1'b1;
                        if (accept) begin
                            start_frame = 1'b1;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                            ready_next = 1'b1;
                            txd_next   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (start_frame) begin
            state_next = START;
            timer_next = '0;
            shreg_next = tx_data;
            par_next   = (PARITY_MODE == 2) ? ~(^tx_data) : (^tx_data);
            txd_next   = 1'b0;
            busy_next  = 1'b1;
            ready_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four parameterisations sharing one stimulus bus,
// expected line bits queued per cycle when a word is driven and popped as the line is sampled.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [8:0] data_bus;
    int         sel;
    logic [3:0] txd_v, ready_v, busy_v, done_v;
    logic       obs_txd, obs_ready, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(valid && (sel == 0)), .tx_data(data_bus[7:0]),
        .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_frame #(.CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst(rst), .tx_valid(valid && (sel == 1)), .tx_data(data_bus[6:0]),
        .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_frame #(.CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
        .clk(clk), .rst(rst), .tx_valid(valid && (sel == 2)), .tx_data(data_bus[6:0]),
        .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx_frame #(.CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .tx_valid(valid && (sel == 3)), .tx_data(data_bus[7:0]),
        .tx_ready(ready_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    assign obs_txd   = txd_v[sel[1:0]];
    assign obs_ready = ready_v[sel[1:0]];
    assign obs_busy  = busy_v[sel[1:0]];
    assign obs_done  = done_v[sel[1:0]];

    // Builds the expected txd value for every cycle of one frame.
    task automatic push_frame(input logic [8:0] d, input int nb, input int pm, input int sb);
        bit p;
        p = 1'b0;
        repeat (10) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (10) exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm != 0) begin
            if (pm == 2) p = ~p;
            repeat (10) exp_q.push_back(p);
        end
        repeat (sb * 10) exp_q.push_back(1'b1);
    endtask

    // Waits for ready on the chosen instance, then presents a word through the acceptance edge.
    task automatic start_send(input int which, input logic [8:0] d, input int nb, input int pm, input int sb);
        int waited;
        waited = 0;
        @(negedge clk);
        sel = which;
        #1;
        while (!obs_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_wait inst %0d got %b expected 1", which, obs_ready);
        end
        data_bus = d;
        valid    = 1'b1;
        push_frame(d, nb, pm, sb);
        @(posedge clk);
    endtask

    // Samples cycles 1..limit of a frame and applies mid-frame pokes after sampling.
    task automatic check_frame(input int nb, input int pm, input int sb, input int limit,
                               input bit done_first, input int release_c, input int poke_c,
                               input logic [8:0] poke_d, input int pulse_c);
        int n;
        bit e;
        n = (1 + nb + ((pm != 0) ? 1 : 0) + sb) * 10;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                e = 1'b1;
                errors++;
                $display("[TB] FAIL queue_empty cycle %0d", c);
            end else begin
                e = exp_q.pop_front();
            end
            checks++;
            if (obs_txd !== e) begin
                errors++;
                $display("[TB] FAIL txd cycle %0d got %b expected %b", c, obs_txd, e);
            end
            checks++;
            if (obs_ready !== (c == n)) begin
                errors++;
                $display("[TB] FAIL tx_ready cycle %0d got %b expected %b", c, obs_ready, (c == n));
            end
            checks++;
            if (obs_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL tx_busy cycle %0d got %b expected 1", c, obs_busy);
            end
            checks++;
            if (obs_done !== (done_first && c == 1)) begin
                errors++;
                $display("[TB] FAIL tx_done cycle %0d got %b expected %b", c, obs_done, (done_first && c == 1));
            end
            if (c == release_c) valid = 1'b0;
            if (c == poke_c) data_bus = poke_d;
            if (pulse_c > 0 && c == pulse_c) valid = 1'b1;
            if (pulse_c > 0 && c == pulse_c + 1) valid = 1'b0;
        end
    endtask

    // Cycle after the last stop bit: done pulse, line idle; then the pulse must be gone.
    task automatic check_idle_end(input string name);
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s done_pulse got %b expected 1", name, obs_done);
        end
        checks++;
        if (obs_busy !== 1'b0 || obs_txd !== 1'b1 || obs_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle_after busy/txd/ready got %b%b%b expected 011", name, obs_busy, obs_txd, obs_ready);
        end
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle_next done/busy/txd got %b%b%b expected 001", name, obs_done, obs_busy, obs_txd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            checks++;
            if ({obs_txd, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
                errors++;
                $display("[TB] FAIL reset_state inst %0d got %b expected 1100", k, {obs_txd, obs_ready, obs_busy, obs_done});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            checks++;
            if ({obs_txd, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
                errors++;
                $display("[TB] FAIL idle_after_reset inst %0d got %b expected 1100", k, {obs_txd, obs_ready, obs_busy, obs_done});
            end
        end
    endtask

    task automatic test_8n1_single();
        start_send(0, 9'h055, 8, 0, 1);
        check_frame(8, 0, 1, 100, 1'b0, 1, 0, 9'h000, 0);
        check_idle_end("8n1_55");
    endtask

    task automatic test_parity();
        start_send(1, 9'h041, 7, 1, 1);
        check_frame(7, 1, 1, 100, 1'b0, 1, 0, 9'h000, 0);
        check_idle_end("7e1_41");
        start_send(2, 9'h041, 7, 2, 1);
        check_frame(7, 2, 1, 100, 1'b0, 1, 0, 9'h000, 0);
        check_idle_end("7o1_41");
    endtask

    task automatic test_back_to_back();
        start_send(0, 9'h0A5, 8, 0, 1);
        push_frame(9'h03C, 8, 0, 1);
        check_frame(8, 0, 1, 100, 1'b0, 0, 1, 9'h03C, 0);
        check_frame(8, 0, 1, 100, 1'b1, 1, 0, 9'h000, 0);
        check_idle_end("b2b_3C");
    endtask

    task automatic test_two_stop();
        start_send(3, 9'h000, 8, 0, 2);
        check_frame(8, 0, 2, 110, 1'b0, 1, 0, 9'h000, 0);
        check_idle_end("8n2_00");
    endtask

    task automatic test_abort();
        start_send(0, 9'h0F0, 8, 0, 1);
        check_frame(8, 0, 1, 44, 1'b0, 1, 0, 9'h000, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs_txd, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL abort_async got %b expected 1100", {obs_txd, obs_ready, obs_busy, obs_done});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({obs_txd, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
                errors++;
                $display("[TB] FAIL abort_quiet cycle %0d got %b expected 1100", c, {obs_txd, obs_ready, obs_busy, obs_done});
            end
        end
        start_send(0, 9'h00F, 8, 0, 1);
        check_frame(8, 0, 1, 100, 1'b0, 1, 0, 9'h000, 0);
        check_idle_end("after_abort_0F");
    endtask

    task automatic test_capture_and_ignore();
        start_send(0, 9'h012, 8, 0, 1);
        check_frame(8, 0, 1, 100, 1'b0, 1, 5, 9'h0FF, 50);
        check_idle_end("capture_12");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        valid    = 1'b0;
        data_bus = '0;
        sel      = 0;
        rst      = 1'b1;
        test_reset();
        test_8n1_single();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_abort();
        test_capture_and_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter and successor to the team's fixed 8N1 transmitter. It supports configurable data width, optional even/odd parity and 1 or 2 stop bits. It also supports zero-gap back-to-back frames and provides busy/done status. It sits between a byte-stream producer using a valid/ready handshake and the serial TXD pin.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD_RATE (integer division, must be >= 2)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_BITS  word to send, LSB first
tx_ready  output  1  transmitter accepts a word this cycle
txd  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values: txd=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. txd returns high asynchronously and no tx_done is generated.
- All outputs are registered.
- States and transitions: IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE=0) -> STOP -> IDLE or START.
- Bit timing: each line bit is held exactly CLKS_PER_BIT cycles, timed by a bit timer of width clog2(CLKS_PER_BIT).
- Acceptance: a transfer occurs on a rising edge where tx_valid && tx_ready. tx_data is captured into a shift register at that edge. Later changes to tx_data have no effect on the frame.
- Latency: txd=0 (start bit) in the first cycle after the acceptance edge. tx_busy=1 from that same cycle.
- DATA: bit i is driven in data period i, LSB first, for i = 0..DATA_BITS-1.
- PARITY:
  - even: parity bit = XOR of the captured data bits.
  - odd: parity bit = inverted XOR.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_ready is 1 in IDLE and in the final cycle of the last stop bit. It is 0 at all other times.
- Acceptance in the final stop cycle moves the FSM directly to START. This gives a seamless back-to-back frame with no extra idle cycle.
- With no acceptance in the final stop cycle, the FSM enters IDLE and tx_busy=0.
- tx_done pulses high for exactly one cycle, in the cycle after the final stop-bit cycle. This holds whether the next state is IDLE or START.
- tx_valid while tx_ready=0 is ignored. There is no queuing; the producer must hold tx_valid.
- tx_data bits above DATA_BITS do not exist. There is no truncation logic.
- Illegal parameter values (DATA_BITS outside 5..9, PARITY_MODE=3, STOP_BITS outside 1..2, CLKS_PER_BIT<2) must fail at elaboration via a generate-time check.

Test Plan:
All scenarios use CLK_HZ=1000000 and BAUD_RATE=100000, giving CLKS_PER_BIT=10. Edge 0 is the acceptance edge.

1. Default 8N1, send 0x55 once.
   -> txd=0 for cycles 1-10, then 1,0,1,0,1,0,1,0 for 10 cycles each, then stop=1 for cycles 91-100.
   -> tx_ready=0 for cycles 1-99 and =1 at cycle 100.
   -> tx_done=1 only at cycle 101; tx_busy=0 from cycle 101.
2. DATA_BITS=7, PARITY_MODE=1, send 0x41.
   -> data bits 1,0,0,0,0,0,1, parity bit 0, frame length 100 cycles.
   -> Repeat with PARITY_MODE=2: parity bit 1.
3. 8N1 with tx_valid held high, send 0xA5 then 0x3C.
   -> Second word accepted at cycle 100.
   -> Second start-bit falling edge at cycle 101, exactly 100 cycles after the first.
   -> tx_done pulse at cycle 101 and again at cycle 201.
4. STOP_BITS=2, send 0x00.
   -> txd low for cycles 1-90, high for cycles 91-110.
   -> tx_ready=1 first at cycle 110.
5. Assert rst asynchronously during data bit 3 (cycle 45) of 0xF0.
   -> txd=1 and tx_ready=1 immediately, with no tx_done.
   -> A subsequent send of 0x0F produces a complete, correct 100-cycle frame.
6. Change tx_data to 0xFF at cycle 5 of a 0x12 frame, and pulse tx_valid at cycle 50.
   -> Line carries 0x12 unaltered.
   -> The cycle-50 request is not accepted; tx_ready remains 0.
